alu_ctl_seq: RTL
================

Name: alu_ctl_seq

Overview:
- Registered, handshaked successor of the datapath ALU control decoder.
- Decodes ALUOp plus the 11-bit R-format opcode into a registered ALUctl word.
- Sequences multi-cycle operations (MUL, optionally shifts) by holding ALUctl stable and pulsing an iteration enable for a parametrised number of cycles.
- Sits between the main control unit and the ALU/multiplier in the multi-cycle datapath; flags illegal opcodes.

Parameters:
OPCODE_W, 11, opcode width; must be >= 11; bits above [10] are ignored by decode
CTL_W, 4, ALUctl width; must be >= 4; upper bits are zero-filled
MUL_CYCLES, 4, iteration cycles for MUL; must be >= 2
SHIFT_CYCLES, 1, iteration cycles for LSL/LSR; 1 means single-cycle

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
ALUOp  in  2  00 load/store add, 01 branch pass-B, 10 R-format, 11 immediate add
OpCode  in  OPCODE_W  instruction opcode field
ALUctl  out  CTL_W  registered ALU control word
out_valid  out  1  ALUctl is final and the result is ready to consume
out_ready  in  1  consumer accepts the result
iter_en  out  1  high during each iteration cycle of a multi-cycle op
iter_cnt  out  clog2(max(MUL_CYCLES,SHIFT_CYCLES))+1  current iteration index
illegal  out  1  the current output is an undecodable R-format opcode
err_sticky  out  1  set on any accepted illegal opcode, cleared only by reset

Behaviour:
- Reset (synchronous; applies mid-operation and abandons any in-flight op):
  - State goes to IDLE.
  - ALUctl=0, out_valid=0, iter_en=0, iter_cnt=0, illegal=0, err_sticky=0, in_ready=1 in the cycle after reset deasserts.
- Decode table:
  - ALUOp 00 -> 2.
  - ALUOp 01 -> 7.
  - ALUOp 11 -> 2.
  - ALUOp 10, keyed on OpCode[10:0]:
    - 1112 ADD -> 2
    - 1624 SUB -> 6
    - 1104 AND -> 0
    - 1360 ORR -> 1
    - 1616 EOR -> 3
    - 1691 LSL -> 4
    - 1690 LSR -> 5
    - 1240 MUL -> 8
    - anything else -> 15 with illegal=1
- States: IDLE, ITER, OUT.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
- Accept occurs when in_valid & in_ready. On accept:
  - Register ALUctl and illegal, and OR illegal into err_sticky.
  - Single-cycle op (including illegal, and shifts when SHIFT_CYCLES==1): go to OUT; out_valid=1 on the next cycle (latency 1).
  - Multi-cycle op with N cycles: go to ITER with iter_cnt=0.
- ITER:
  - iter_en=1, out_valid=0, in_ready=0; ALUctl held.
  - iter_cnt increments each cycle.
  - When iter_cnt==N-1, go to OUT next cycle. Total latency accept->out_valid = N+1 cycles.
- OUT:
  - out_valid=1, iter_en=0; ALUctl and illegal held until out_ready.
  - out_ready=1 without a simultaneous accept: go to IDLE; out_valid=0 next cycle.
  - out_ready=1 with a simultaneous accept (back-to-back): load the new request directly; out_valid stays 1 only if the new op is single-cycle.
- Outputs are never modified while out_valid=1 & out_ready=0 (stall-stable).
- in_valid while in_ready=0 is ignored; the requester must hold it.
- Decode is a pure function of the inputs on the accept edge; later changes to ALUOp/OpCode have no effect.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, in_ready=1; ALUOp=00, in_valid=1 -> next cycle ALUctl=2, out_valid=1.
- ALUOp=10, OpCode=1624, out_ready=1 continuously, followed back-to-back by OpCode=1104 -> ALUctl 6 then 0 on consecutive cycles, out_valid constant 1, in_ready constant 1.
- ALUOp=10, OpCode=1240, MUL_CYCLES=4 -> iter_en high 4 cycles with iter_cnt 0,1,2,3, ALUctl=8 throughout, out_valid on cycle 5, in_ready=0 during ITER.
- ALUOp=10, OpCode=1234 -> ALUctl=15, illegal=1, err_sticky=1; next legal op -> illegal=0, err_sticky remains 1 until reset.
- ALUOp=10, OpCode=1360 with out_ready=0 for 3 cycles while OpCode/ALUOp toggle -> ALUctl stays 1 and out_valid stays 1; release -> IDLE.
- Reset asserted at iter_cnt=2 of a MUL -> next cycle IDLE, iter_en=0, out_valid=0, err_sticky=0; SHIFT_CYCLES=3 build with LSL (1691) -> 3 iterations, ALUctl=4.

Source files
------------

// File: rtl/alu_ctl_seq.sv
// rtl/alu_ctl_seq.sv - registered, handshaked ALU control decoder with multi-cycle op sequencing
module alu_ctl_seq #(
   parameter int OPCODE_W     = 11,
   parameter int CTL_W        = 4,
   parameter int MUL_CYCLES   = 4,
   parameter int SHIFT_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          ALUOp,
   input  logic [OPCODE_W-1:0] OpCode,
   output logic [CTL_W-1:0]    ALUctl,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                iter_en,
   output logic [$clog2((MUL_CYCLES > SHIFT_CYCLES) ? MUL_CYCLES : SHIFT_CYCLES):0] iter_cnt,
   output logic                illegal,
   output logic                err_sticky
);

   localparam int MAX_CYC = (MUL_CYCLES > SHIFT_CYCLES) ? MUL_CYCLES : SHIFT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [3:0]       ctl_q, ctl_d;
   logic             ill_q, ill_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] last_q, last_d;

   logic [3:0]       dec_ctl;
   logic             dec_ill;
   logic [CNT_W-1:0] dec_last;
   logic             accept;

   // Decode the request into a control word, illegal flag and final iteration index
   always_comb begin
      dec_ctl  = 4'd15;
      dec_ill  = 1'b0;
      dec_last = '0;
      case (ALUOp)
         2'b00, 2'b11: dec_ctl = 4'd2;
         2'b01:        dec_ctl = 4'd7;
         default: begin
            case (OpCode[10:0])
               11'd1112: dec_ctl = 4'd2;
               11'd1624: dec_ctl = 4'd6;
               11'd1104: dec_ctl = 4'd0;
               11'd1360: dec_ctl = 4'd1;
               11'd1616: dec_ctl = 4'd3;
               11'd1691: begin
                  dec_ctl  = 4'd4;
                  dec_last = CNT_W'(SHIFT_CYCLES - 1);
               end
               11'd1690: begin
                  dec_ctl  = 4'd5;
                  dec_last = CNT_W'(SHIFT_CYCLES - 1);
               end
               11'd1240: begin
                  dec_ctl  = 4'd8;
                  dec_last = CNT_W'(MUL_CYCLES - 1);
               end
               default: begin
                  dec_ctl = 4'd15;
                  dec_ill = 1'b1;
               end
            endcase
         end
      endcase
   end

   // A new request may load in IDLE, or in OUT when the held result is consumed this cycle
   assign in_ready = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready);
   assign accept   = in_valid & in_ready;

   // Next-state logic: load on accept, count through ITER, release OUT on out_ready
   always_comb begin
      state_d = state_q;
      ctl_d   = ctl_q;
      ill_d   = ill_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE, S_OUT: begin
            if (accept) begin
               ctl_d   = dec_ctl;
               ill_d   = dec_ill;
               err_d   = err_q | dec_ill;
               last_d  = dec_last;
               cnt_d   = '0;
               state_d = (dec_last != '0) ? S_ITER : S_OUT;
            end else if ((state_q == S_OUT) && out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_ITER: begin
            if (cnt_q == last_q) begin
               state_d = S_OUT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset that abandons any in-flight op
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ctl_q   <= 4'd0;
         ill_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_d;
         ill_q   <= ill_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign ALUctl     = CTL_W'(ctl_q);
   assign out_valid  = (state_q == S_OUT);
   assign iter_en    = (state_q == S_ITER);
   assign iter_cnt   = cnt_q;
   assign illegal    = ill_q;
   assign err_sticky = err_q;

endmodule
